// File: rtl/streak_game_fsm.sv
// rtl/streak_game_fsm.sv - win-streak referee for the rock-paper-scissors datapath
module streak_game_fsm #(
    parameter int WIN_TARGET  = 3,
    parameter int LIVES       = 1,
    parameter int DRAW_BREAKS = 0,
    parameter int MAX_ROUNDS  = 0,
    localparam int SW = $clog2(WIN_TARGET + 1),
    localparam int LW = $clog2(LIVES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            signal,
    input  logic                  signal_valid,
    input  logic                  start,
    output logic [WIN_TARGET-1:0] light_output,
    output logic [1:0]            status,
    output logic [SW-1:0]         streak,
    output logic [LW-1:0]         lives_left,
    output logic [7:0]            round_count,
    output logic [SW-1:0]         best_streak
);

    // State encoding doubles as the status code so status is a plain register.
    typedef enum logic [1:0] {
        S_LOST = 2'b00,
        S_PLAY = 2'b01,
        S_IDLE = 2'b10,
        S_WON  = 2'b11
    } state_t;

    localparam logic [SW-1:0]         WIN_T   = SW'(WIN_TARGET);
    localparam logic [LW-1:0]         LIVES_V = LW'(LIVES);
    localparam logic [7:0]            MAX_R   = 8'(MAX_ROUNDS);
    localparam logic [WIN_TARGET-1:0] ONES    = '1;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [7:0]    rounds_q, rounds_d;
    logic [SW-1:0] best_q, best_d;
    logic [7:0]    rounds_inc;
    logic          round_taken;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        lives_d     = lives_q;
        rounds_d    = rounds_q;
        best_d      = best_q;
        rounds_inc  = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
        round_taken = (state_q == S_PLAY) && signal_valid && (signal != 2'b10);

        if (start) begin
            state_d  = S_PLAY;
            streak_d = '0;
            lives_d  = LIVES_V;
            rounds_d = '0;
        end else if (round_taken) begin
            rounds_d = rounds_inc;
            case (signal)
                2'b11: begin
                    streak_d = streak_q + 1'b1;
                    if (streak_d == WIN_T) state_d = S_WON;
                end
                2'b01: begin
                    if (DRAW_BREAKS != 0) streak_d = '0;
                end
                default: begin
                    streak_d = '0;
                    lives_d  = lives_q - 1'b1;
                    if (lives_q == LW'(1)) state_d = S_LOST;
                end
            endcase
            // A win on the last allowed round beats the round limit.
            if ((MAX_ROUNDS != 0) && (rounds_inc == MAX_R) && (state_d != S_WON))
                state_d = S_LOST;
            if (streak_d > best_q) best_d = streak_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
            lives_q  <= LIVES_V;
            rounds_q <= '0;
            best_q   <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            lives_q  <= lives_d;
            rounds_q <= rounds_d;
            best_q   <= best_d;
        end
    end

    // Thermometer fills from the MSB; terminal states light everything.
    always_comb begin
        case (state_q)
            S_IDLE:  light_output = '0;
            S_PLAY:  light_output = ~(ONES >> streak_q);
            default: light_output = ONES;
        endcase
    end

    assign status      = state_q;
    assign streak      = streak_q;
    assign lives_left  = lives_q;
    assign round_count = rounds_q;
    assign best_streak = best_q;

endmodule

// File: tb/tb_streak_game_fsm.sv
// tb/tb_streak_game_fsm.sv - scoreboard bench driving four parameterisations of streak_game_fsm
module tb_streak_game_fsm;

    logic       clk;
    logic       rst_n;
    logic [1:0] sig;
    logic       sig_valid;
    logic       start;

    typedef struct packed {
        logic [15:0] light;
        logic [1:0]  status;
        logic [7:0]  streak;
        logic [7:0]  lives;
        logic [7:0]  rounds;
        logic [7:0]  best;
    } obs_t;

    typedef struct {
        obs_t e [4];
    } exp_set_t;

    exp_set_t exp_q[$];
    obs_t     got [4];
    int       vectors;
    int       miscompares;

    // Bench-side game model: phase 0 idle, 1 playing, 2 won, 3 lost.
    int m_phase  [4];
    int m_streak [4];
    int m_lives  [4];
    int m_rounds [4];
    int m_best   [4];

    function automatic int cfg_wt(input int k);
        case (k) 3: return 4; default: return 3; endcase
    endfunction
    function automatic int cfg_lives(input int k);
        case (k) 1: return 2; 3: return 3; default: return 1; endcase
    endfunction
    function automatic int cfg_db(input int k);
        return (k == 1 || k == 3) ? 1 : 0;
    endfunction
    function automatic int cfg_mr(input int k);
        return (k == 2) ? 4 : 0;
    endfunction

    logic [2:0] lo0, lo1, lo2;
    logic [3:0] lo3;
    logic [1:0] st0, st1, st2, st3;
    logic [1:0] sk0, sk1, sk2, bs0, bs1, bs2;
    logic [2:0] sk3, bs3;
    logic       lv0, lv2;
    logic [1:0] lv1, lv3;
    logic [7:0] rc0, rc1, rc2, rc3;

    streak_game_fsm #(.WIN_TARGET(3), .LIVES(1), .DRAW_BREAKS(0), .MAX_ROUNDS(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .signal(sig), .signal_valid(sig_valid), .start(start),
        .light_output(lo0), .status(st0), .streak(sk0), .lives_left(lv0),
        .round_count(rc0), .best_streak(bs0));
    streak_game_fsm #(.WIN_TARGET(3), .LIVES(2), .DRAW_BREAKS(1), .MAX_ROUNDS(0)) u_dut1 (
        .clk(clk), .reset(rst_n), .signal(sig), .signal_valid(sig_valid), .start(start),
        .light_output(lo1), .status(st1), .streak(sk1), .lives_left(lv1),
        .round_count(rc1), .best_streak(bs1));
    streak_game_fsm #(.WIN_TARGET(3), .LIVES(1), .DRAW_BREAKS(0), .MAX_ROUNDS(4)) u_dut2 (
        .clk(clk), .reset(rst_n), .signal(sig), .signal_valid(sig_valid), .start(start),
        .light_output(lo2), .status(st2), .streak(sk2), .lives_left(lv2),
        .round_count(rc2), .best_streak(bs2));
    streak_game_fsm #(.WIN_TARGET(4), .LIVES(3), .DRAW_BREAKS(1), .MAX_ROUNDS(0)) u_dut3 (
        .clk(clk), .reset(rst_n), .signal(sig), .signal_valid(sig_valid), .start(start),
        .light_output(lo3), .status(st3), .streak(sk3), .lives_left(lv3),
        .round_count(rc3), .best_streak(bs3));

    assign got[0] = {16'(lo0), st0, 8'(sk0), 8'(lv0), rc0, 8'(bs0)};
    assign got[1] = {16'(lo1), st1, 8'(sk1), 8'(lv1), rc1, 8'(bs1)};
    assign got[2] = {16'(lo2), st2, 8'(sk2), 8'(lv2), rc2, 8'(bs2)};
    assign got[3] = {16'(lo3), st3, 8'(sk3), 8'(lv3), rc3, 8'(bs3)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model_obs(input int k);
        obs_t o;
        int   wt;
        wt = cfg_wt(k);
        o  = '0;
        case (m_phase[k])
            0: o.status = 2'b10;
            1: o.status = 2'b01;
            2: o.status = 2'b11;
            default: o.status = 2'b00;
        endcase
        for (int i = 0; i < wt; i++) begin
            if (m_phase[k] >= 2 || (m_phase[k] == 1 && i < m_streak[k]))
                o.light[wt-1-i] = 1'b1;
        end
        o.streak = 8'(m_streak[k]);
        o.lives  = 8'(m_lives[k]);
        o.rounds = 8'(m_rounds[k]);
        o.best   = 8'(m_best[k]);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_phase[k]  = 0;
            m_streak[k] = 0;
            m_lives[k]  = cfg_lives(k);
            m_rounds[k] = 0;
            m_best[k]   = 0;
        end
    endtask

    task automatic model_apply(input int k, input logic st, input logic v, input logic [1:0] s);
        bit won;
        bit out;
        won = 0;
        out = 0;
        if (st) begin
            m_phase[k]  = 1;
            m_streak[k] = 0;
            m_lives[k]  = cfg_lives(k);
            m_rounds[k] = 0;
        end else if (m_phase[k] == 1 && v && s != 2'b10) begin
            if (m_rounds[k] < 255) m_rounds[k]++;
            if (s == 2'b11) begin
                m_streak[k]++;
                won = (m_streak[k] == cfg_wt(k));
            end else if (s == 2'b01) begin
                if (cfg_db(k) != 0) m_streak[k] = 0;
            end else begin
                m_streak[k] = 0;
                m_lives[k]--;
                out = (m_lives[k] == 0);
            end
            if (m_streak[k] > m_best[k]) m_best[k] = m_streak[k];
            if (won) m_phase[k] = 2;
            else if (out || (cfg_mr(k) != 0 && m_rounds[k] == cfg_mr(k))) m_phase[k] = 3;
        end
    endtask

    task automatic push_expected();
        exp_set_t es;
        for (int k = 0; k < 4; k++) es.e[k] = model_obs(k);
        exp_q.push_back(es);
    endtask

    task automatic check(input int k, input obs_t e, input string tag);
        vectors++;
        if (got[k] !== e) begin
            miscompares++;
            $display("FAIL %s cfg%0d t=%0t: got light=%h status=%b streak=%0d lives=%0d rounds=%0d best=%0d, expected light=%h status=%b streak=%0d lives=%0d rounds=%0d best=%0d",
                     tag, k, $time, got[k].light, got[k].status, got[k].streak, got[k].lives,
                     got[k].rounds, got[k].best, e.light, e.status, e.streak, e.lives,
                     e.rounds, e.best);
        end
    endtask

    task automatic step(input logic st, input logic v, input logic [1:0] s);
        @(negedge clk);
        rst_n     = 1'b1;
        start     = st;
        sig_valid = v;
        sig       = s;
        for (int k = 0; k < 4; k++) model_apply(k, st, v, s);
        push_expected();
    endtask

    // Reset pulled low between edges; outputs must clear before any clock.
    task automatic async_reset();
        @(negedge clk);
        start     = 1'b0;
        sig_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 4; k++) check(k, model_obs(k), "async_reset");
        push_expected();
    endtask

    initial begin
        exp_set_t es;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                es = exp_q.pop_front();
                for (int k = 0; k < 4; k++) check(k, es.e[k], "edge");
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        sig_valid   = 1'b0;
        sig         = 2'b00;
        model_reset();
        @(negedge clk);
        push_expected();

        step(1, 0, 2'b00);
        repeat (3) step(0, 1, 2'b11);
        step(0, 1, 2'b11);

        step(1, 0, 2'b00);
        step(0, 1, 2'b11); step(0, 1, 2'b11); step(0, 1, 2'b00);
        repeat (2) step(0, 1, 2'b11);

        step(1, 0, 2'b00);
        step(0, 1, 2'b11); step(0, 1, 2'b01); step(0, 1, 2'b00); step(0, 1, 2'b11);

        step(1, 0, 2'b00);
        step(0, 1, 2'b01); step(0, 1, 2'b01); step(0, 1, 2'b11); step(0, 1, 2'b01);
        step(1, 0, 2'b00);
        step(0, 1, 2'b01); step(0, 1, 2'b11); step(0, 1, 2'b11); step(0, 1, 2'b11);

        step(1, 0, 2'b00);
        step(0, 1, 2'b11); step(0, 1, 2'b11);
        step(1, 1, 2'b11);
        repeat (3) step(0, 1, 2'b10);

        step(1, 0, 2'b00);
        step(0, 1, 2'b11); step(0, 1, 2'b11);
        async_reset();
        step(0, 1, 2'b11); step(0, 1, 2'b11);
        step(1, 0, 2'b00); step(0, 1, 2'b11);

        step(1, 0, 2'b00);
        repeat (300) step(0, 1, 2'b01);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0)
                async_reset();
            else
                step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 2'($urandom));
        end

        @(negedge clk);
        start     = 1'b0;
        sig_valid = 1'b0;
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/streak_game_fsm.md
Name: streak_game_fsm

Overview:
Parametrised win-streak referee for the rock-paper-scissors arcade datapath. It consumes one round result per valid strobe and tracks the current consecutive-win streak. It also tracks remaining lives, round count and best streak, and declares the game won, lost or in progress. It sits between the round-judge logic and the LED/status display. It generalises the fixed 3-win, 1-loss game to configurable targets, lives, draw policy and round limit, with an explicit start/idle phase.

Parameters:
WIN_TARGET, 3, consecutive wins needed to win the game (1..15)
LIVES, 1, losses that end the game (1..7)
DRAW_BREAKS, 0, 0: draw leaves streak unchanged; 1: draw clears streak to 0
MAX_ROUNDS, 0, 0: unlimited rounds; otherwise game lost when this many rounds are played without a win (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; all state is cleared while low
signal  input  2  round result: 00 lose, 01 draw, 11 win, 10 reserved
signal_valid  input  1  signal is sampled on this clock edge when high
start  input  1  begin (or restart) a game
light_output  output  WIN_TARGET  thermometer streak display
status  output  2  00 lost, 01 in progress, 11 won, 10 idle
streak  output  SW=$clog2(WIN_TARGET+1)  current consecutive wins
lives_left  output  LW=$clog2(LIVES+1)  remaining lives
round_count  output  8  valid rounds played in this game, saturating at 255
best_streak  output  SW  longest streak since reset

Behaviour:
- Reset: the port is asynchronous and active-low. State goes to IDLE; streak=0, lives_left=LIVES, round_count=0, best_streak=0, light_output=0, status=10.
- All outputs are registered or decoded only from registers. A result sampled at edge N is visible after edge N (latency 1).
- States: IDLE, PLAY, WON, LOST. Encoding is free.
- IDLE: the block ignores signal_valid. start=1 -> PLAY with streak=0, lives_left=LIVES, round_count=0.
- PLAY, on signal_valid=1, acts by signal code:
  - 11 (win): streak+1 and round_count+1. If the new streak == WIN_TARGET, go to WON.
  - 01 (draw): round_count+1. Streak is unchanged, or cleared to 0 if DRAW_BREAKS=1.
  - 00 (lose): streak=0, lives_left-1, round_count+1. If lives_left was 1, go to LOST (lives_left=0).
  - 10 (reserved): fully ignored. No counter changes and not counted as a round.
- Round limit: if MAX_ROUNDS!=0 and the new round_count == MAX_ROUNDS and the round did not produce WON, go to LOST. Winning on the final round takes priority over the limit. A loss that exhausts lives on the final round goes to LOST either way.
- best_streak: updated to max(best_streak, new streak) in the same cycle as the streak update. Cleared only by reset; it persists across games.
- WON and LOST: terminal. Ignore signal_valid. Counters are frozen and readable.
- start while in PLAY, WON or LOST: restart into PLAY (streak, lives and round_count reinitialised; best_streak kept).
- start and signal_valid in the same cycle: start takes priority and the result is discarded.
- light_output:
  - IDLE: all 0.
  - PLAY: the top `streak` bits are set, filling from the MSB downward. Example, WIN_TARGET=3, streak=1 -> 100; streak=2 -> 110.
  - WON and LOST: all 1.
- status: IDLE 10, PLAY 01, WON 11, LOST 00.
- Reset asserted mid-game: immediate return to IDLE with reset values. No partial update is retained.
- round_count saturates at 255 when MAX_ROUNDS=0; no wrap.

Test Plan:
- Defaults; reset, start, then wins 11,11,11 on three valid cycles -> light_output 100, 110, then 111 with status=11. streak=3, best_streak=3, round_count=3.
- Defaults; start, then win, win, lose -> lights 100, 110, then LOST with light_output=111, status=00, lives_left=0. Further valid wins cause no change.
- LIVES=2, DRAW_BREAKS=1; start, then win, draw, lose, win -> streak 1,0,0,1 and lives_left 2,2,1,1. status stays 01 and round_count=4.
- MAX_ROUNDS=4, WIN_TARGET=3; start, then draw, draw, win, draw -> LOST on round 4. Separately: start, then draw, win, win, win (third win on round 4) -> WON (status=11).
- Mid-game, start and signal_valid (win) in the same cycle -> streak=0, round_count=0, lives_left=LIVES, status=01. best_streak is kept, and signal=10 pulses change nothing.
- Pull reset low asynchronously, between clock edges, during PLAY with streak=2 -> outputs go to reset values immediately, status=10. After release, start is required before results are counted.
